// File: rtl/gray_pkg.sv
// Shared Gray-code constants and helpers, reused by the counter and the gray_to_binary block.
package gray_pkg;

   localparam int DEFAULT_WIDTH = 3;
   localparam int MAX_WIDTH     = 16;

   // Works for any width up to MAX_WIDTH; narrower callers zero-extend and truncate.
   function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Purely combinational binary-to-Gray encoder.
module binary_to_gray #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with loadable value, registered Gray output and wrap pulse.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             wrap
);

   logic [WIDTH-1:0] bin_d,  bin_q;
   logic [WIDTH-1:0] gray_d, gray_q;
   logic             wrap_d, wrap_q;

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_bin;
      end else if (en) begin
         if (up) begin
            bin_d  = bin_q + 1'b1;
            wrap_d = &bin_q;
         end else begin
            bin_d  = bin_q - 1'b1;
            wrap_d = ~|bin_q;
         end
      end
   end

   // Encode the next binary value so gray lands on the same edge as bin.
   binary_to_gray #(.WIDTH(WIDTH)) u_enc (
      .bin  (bin_d),
      .gray (gray_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin  = bin_q;
   assign gray = gray_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Randomized and directed checks of gray_code_counter against an arithmetic reference model.
module tb_gray_code_counter;

   localparam int W = 3;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
   logic [W-1:0] load_bin = '0;
   logic [W-1:0] bin, gray;
   logic         wrap;

   int n_chk  = 0;
   int n_fail = 0;

   int m_bin = 0, m_wrap = 0;
   bit m_valid = 0, m_step = 0;

   gray_code_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic int to_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   // Reference decoder: each binary bit is the XOR of all gray bits at or above it.
   function automatic int from_gray(input int g);
      int b = 0;
      for (int i = W - 1; i >= 0; i--)
         b |= (((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i;
      return b;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit l, input int lb, input bit e, input bit u);
      rst = r; load = l; load_bin = W'(lb); en = e; up = u;
      @(posedge clk);
      m_step = 0;
      if (r) begin
         m_bin = 0; m_wrap = 0; m_valid = 1;
      end else if (l) begin
         m_bin = lb % N; m_wrap = 0;
      end else if (e) begin
         m_step = 1;
         if (u) begin
            m_wrap = (m_bin == N - 1);
            m_bin  = (m_bin + 1) % N;
         end else begin
            m_wrap = (m_bin == 0);
            m_bin  = (m_bin + N - 1) % N;
         end
      end else begin
         m_wrap = 0;
      end
      #1;
   endtask

   int prev_gray = 0;
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_bin", int'(bin), m_bin);
         chk("model_gray", int'(gray), to_gray(m_bin));
         chk("model_wrap", int'(wrap), m_wrap);
         chk("roundtrip", from_gray(int'(gray)), int'(bin));
         if (m_step) chk("one_bit_change", $countones(W'(gray) ^ W'(prev_gray)), 1);
         prev_gray = int'(gray);
      end
   end

   int up_gray[8] = '{1, 3, 2, 6, 7, 5, 4, 0};

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_bin", int'(bin), 0);
      chk("reset_gray", int'(gray), 0);
      chk("reset_wrap", int'(wrap), 0);

      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 1, 1);
         chk("up_gray", int'(gray), up_gray[i]);
         chk("up_wrap", int'(wrap), (i == 7) ? 1 : 0);
      end

      step(0, 0, 0, 1, 0);
      chk("down_wrap_bin", int'(bin), 7);
      chk("down_wrap_gray", int'(gray), 4);
      chk("down_wrap_wrap", int'(wrap), 1);
      step(0, 0, 0, 1, 0);
      chk("down_next_bin", int'(bin), 6);
      chk("down_next_gray", int'(gray), 5);
      chk("down_next_wrap", int'(wrap), 0);

      step(0, 1, 2, 0, 0);
      chk("load_setup_bin", int'(bin), 2);
      step(0, 1, 5, 1, 1);
      chk("load_prio_bin", int'(bin), 5);
      chk("load_prio_gray", int'(gray), 7);
      chk("load_prio_wrap", int'(wrap), 0);

      step(0, 0, 0, 1, 1);
      chk("pre_rst_bin", int'(bin), 6);
      step(1, 1, 3, 1, 1);
      chk("mid_rst_bin", int'(bin), 0);
      chk("mid_rst_gray", int'(gray), 0);
      step(0, 0, 0, 1, 1);
      chk("post_rst_gray", int'(gray), 1);

      step(0, 0, 0, 0, 1);
      chk("hold_bin", int'(bin), 1);
      chk("hold_wrap", int'(wrap), 0);

      for (int i = 0; i < 16; i++)
         step(0, 0, 0, 1, 1'($urandom_range(0, 1)));

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)));

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
